apb_arb_2m: RTL and testbench
=============================

Name: apb_arb_2m

Overview:
- Two-requester APB master front end for the mini crypto accelerator's shared APB segment.
- Crypto-engine config port (requester 0) and SPI host (requester 1) request single APB transfers over a simple req/done interface.
- Block arbitrates round-robin, runs the APB SETUP/ACCESS sequence and decodes the address into a 2-bit one-hot psel.
- Returns prdata and pslverr to the winning requester.

Parameters:
- ADDR_W, 20, APB address width.
- DATA_W, 16, APB data width.
- SEL_BIT, 19, paddr bit that selects the slave: 0 gives psel=2'b01, 1 gives psel=2'b10.
- TIMEOUT_CYC, 255, ACCESS-phase wait limit in cycles. Used only with APB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req0, req1  in  1 each  transfer request; held high until done
- addr0, addr1  in  ADDR_W each  transfer address
- wdata0, wdata1  in  DATA_W each  write data
- write0, write1  in  1 each  1=write, 0=read
- strb0, strb1  in  DATA_W/8 each  write byte strobes
- done0, done1  out  1 each  one-cycle completion pulse to the owner
- rdata  out  DATA_W  read data; valid while a done is high
- err  out  1  slave error or timeout; valid while a done is high
- psel  out  2  one-hot slave select
- penable  out  1  APB enable
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- pwrite  out  1  APB direction
- pstrb  out  DATA_W/8  APB strobes
- prdata  in  DATA_W  slave read data
- pready  in  1  slave ready
- pslverr  in  1  slave error

Behaviour:
- All outputs are registered.
- Reset (asynchronous, immediate, any state): all outputs 0, FSM to IDLE, priority pointer to requester 0, timeout counter 0. A transfer in flight is abandoned and no done is issued.
- FSM states and transitions:
  - IDLE: if any req is high, grant it, latch its addr/wdata/write/strb, record owner, go to SETUP.
  - SETUP: psel = decoded one-hot, penable=0, paddr/pwrite/pstrb/pwdata driven. Always go to ACCESS next cycle.
  - ACCESS: penable=1, all bus fields held stable. On pready=1: capture prdata (reads only; writes capture 0) into rdata and pslverr into err, drop psel/penable, go to DONE.
  - DONE: done<owner>=1 for exactly one cycle, rdata/err stable, go to IDLE. All bus outputs are 0 in DONE and IDLE.
- Minimum transfer is 4 cycles (IDLE grant, SETUP, ACCESS, DONE). Each pready=0 cycle in ACCESS adds one cycle.
- Arbitration:
  - Only one requester high: it wins.
  - Both high: the requester holding priority wins.
  - After any grant, priority passes to the other requester.
- Handshake rules:
  - Requester keeps req and its payload stable from assertion until done. Payload is latched at grant, so later changes are ignored.
  - Requester must drop or refresh req in the cycle done is high. The block re-samples req only in IDLE, one cycle after DONE.
  - req dropping mid-transfer does not abort the transfer; done is still issued.
- Reads drive pstrb=0 and pwdata=0 (APB4 rule).
- rdata and err clear to 0 in the cycle after DONE.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined: counter increments each ACCESS cycle with pready=0. When it reaches TIMEOUT_CYC, the transfer is aborted: psel/penable drop, FSM goes to DONE with err=1 and rdata=16'hDEAD. A late pready after abort is ignored. Counter clears on SETUP.
- Undefined: no counter; ACCESS waits indefinitely for pready.

Decomposition:
- Package apb_icn_pkg holds:
  - ADDR_W/DATA_W/STRB_W defaults
  - FSM state enum (IDLE, SETUP, ACCESS, DONE)
  - psel one-hot codes
  - timeout rdata constant 16'hDEAD
- One sub-module, rr_arb2: 2-way round-robin arbiter with priority pointer register, inputs req[1:0] and a grant-enable, output one-hot gnt[1:0].

Test Plan:
- Write, no contention: req0 with addr0=20'h00010, wdata0=16'h1234, strb0=2'b11, pready tied 1 -> psel=01 in SETUP, penable=1 next cycle, done0 in cycle 4, err=0.
- Read to slave 1: req1 with addr1=20'h80004, write1=0, prdata=16'hABCD, 3 pready=0 wait cycles -> psel=10, pstrb=0, done1 with rdata=16'hABCD after 7 cycles.
- Contention: req0 and req1 both held continuously -> grants alternate 0,1,0,1 over 4 transfers; each done only to its owner.
- Slave error: pslverr=1 with pready=1 -> err=1 alongside done; the next transfer has err=0.
- Reset mid-ACCESS: reset_n low while penable=1 -> psel/penable/done 0 immediately; after release, both requesters high -> requester 0 wins.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYC=8): pready held 0 -> abort after 8 ACCESS cycles, done with err=1, rdata=16'hDEAD. With the macro undefined, the bus still waits at cycle 100.

Source files
------------

// File: rtl/apb_icn_pkg.sv
// Shared types and constants for the crypto accelerator's APB segment master front end.
package apb_icn_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 16;
    localparam int STRB_W_DEF = DATA_W_DEF / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } apb_state_t;

    localparam logic [1:0] PSEL_S0 = 2'b01;
    localparam logic [1:0] PSEL_S1 = 2'b10;

    // Read data returned when an ACCESS phase is abandoned on timeout.
    localparam logic [15:0] TIMEOUT_RDATA = 16'hDEAD;

    function automatic logic [1:0] psel_decode(input logic sel_bit);
        return sel_bit ? PSEL_S1 : PSEL_S0;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; priority passes to the other requester after every grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic prio;  // 0: requester 0 wins a tie, 1: requester 1 wins a tie

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[0] && (!req[1] || !prio)) begin
                gnt = 2'b01;
            end else if (req[1]) begin
                gnt = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio <= 1'b0;
        end else if (|gnt) begin
            prio <= gnt[0];
        end
    end

endmodule

// File: rtl/apb_arb_2m.sv
// Two-requester APB master: round-robin grant, SETUP/ACCESS sequencing, one-hot psel decode.
// Optional ACCESS-phase timeout is compiled in with APB_TIMEOUT_EN.
module apb_arb_2m
    import apb_icn_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SEL_BIT     = 19,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req0,
    input  logic                req1,
    input  logic [ADDR_W-1:0]   addr0,
    input  logic [ADDR_W-1:0]   addr1,
    input  logic [DATA_W-1:0]   wdata0,
    input  logic [DATA_W-1:0]   wdata1,
    input  logic                write0,
    input  logic                write1,
    input  logic [DATA_W/8-1:0] strb0,
    input  logic [DATA_W/8-1:0] strb1,
    output logic                done0,
    output logic                done1,
    output logic [DATA_W-1:0]   rdata,
    output logic                err,
    output logic [1:0]          psel,
    output logic                penable,
    output logic [ADDR_W-1:0]   paddr,
    output logic [DATA_W-1:0]   pwdata,
    output logic                pwrite,
    output logic [DATA_W/8-1:0] pstrb,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pready,
    input  logic                pslverr
);

    // Requester handshake: reqN rises with a stable payload and stays high until doneN pulses
    // for one cycle; payload is latched at grant, and req is re-sampled only back in IDLE.
    apb_state_t state;
    logic       owner;
    logic [1:0] gnt;
    logic       timeout_hit;

    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_write;
    logic [DATA_W/8-1:0] sel_strb;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({req1, req0}),
        .en      (state == ST_IDLE),
        .gnt     (gnt)
    );

    always_comb begin
        sel_addr  = gnt[1] ? addr1  : addr0;
        sel_wdata = gnt[1] ? wdata1 : wdata0;
        sel_write = gnt[1] ? write1 : write0;
        sel_strb  = gnt[1] ? strb1  : strb0;
    end

`ifdef APB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;

    // This is the TIMEOUT_CYC-th ACCESS cycle without pready.
    always_comb begin
        timeout_hit = 1'b0;
        if (state == ST_ACCESS && !pready && to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            timeout_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
        end else if (state == ST_SETUP) begin
            to_cnt <= '0;
        end else if (state == ST_ACCESS && !pready && !timeout_hit) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC == 0);

    always_comb begin
        timeout_hit = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            owner   <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            rdata   <= '0;
            err     <= 1'b0;
            psel    <= 2'b00;
            penable <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
            pwrite  <= 1'b0;
            pstrb   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        owner  <= gnt[1];
                        paddr  <= sel_addr;
                        pwrite <= sel_write;
                        pwdata <= sel_write ? sel_wdata : '0;
                        pstrb  <= sel_write ? sel_strb : '0;
                        psel   <= psel_decode(sel_addr[SEL_BIT]);
                        state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable <= 1'b1;
                    state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pready || timeout_hit) begin
                        if (pready) begin
                            rdata <= pwrite ? '0 : prdata;
                            err   <= pslverr;
                        end else begin
                            rdata <= DATA_W'(TIMEOUT_RDATA);
                            err   <= 1'b1;
                        end
                        done0   <= ~owner;
                        done1   <= owner;
                        psel    <= 2'b00;
                        penable <= 1'b0;
                        paddr   <= '0;
                        pwdata  <= '0;
                        pwrite  <= 1'b0;
                        pstrb   <= '0;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    rdata <= '0;
                    err   <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_arb_2m.sv
// Directed bench for apb_arb_2m with a latency-programmable slave and a completion scoreboard.
module tb_apb_arb_2m;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              req0 = 1'b0, req1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
    logic              write0 = 1'b0, write1 = 1'b0;
    logic [1:0]        strb0 = '0, strb1 = '0;
    logic              done0, done1, err, penable, pwrite, pready, pslverr;
    logic [DATA_W-1:0] rdata, pwdata, prdata;
    logic [1:0]        psel, pstrb;
    logic [ADDR_W-1:0] paddr;

    // slave model: pready rises after slv_wait stalled ACCESS cycles
    int          acc_cnt = 0;
    int          slv_wait = 0;
    logic [15:0] slv_rdata = '0;
    logic        slv_err = 1'b0;

    // scoreboard entry: {owner, err, rdata}
    logic [17:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc;

    apb_arb_2m #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_BIT(19), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .write0(write0), .write1(write1),
        .strb0(strb0), .strb1(strb1), .done0(done0), .done1(done1),
        .rdata(rdata), .err(err), .psel(psel), .penable(penable),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .pstrb(pstrb),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) acc_cnt <= (penable && !pready) ? acc_cnt + 1 : 0;
    assign pready  = penable && (acc_cnt == slv_wait);
    assign prdata  = slv_rdata;
    assign pslverr = slv_err && pready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_done(input int max, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!(done0 || done1) && cycles < max);
        check("done_seen", 32'(done0 || done1), 32'd1);
    endtask

    // completion monitor: every done must match the oldest expected result
    always @(negedge clk) begin
        if (reset_n && (done0 || done1)) begin
            check("single_done", 32'(done0 && done1), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                check("done_result", 32'({done1, err, rdata}), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_outputs", 32'({done0, done1, err, psel, penable, pwrite}), 32'd0);
        check("rst_bus", 32'(paddr | pwdata | rdata), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // write to slave 0, no wait states
        req0 = 1'b1; addr0 = 20'h00010; wdata0 = 16'h1234; write0 = 1'b1; strb0 = 2'b11;
        slv_wait = 0;
        exp_q.push_back({1'b0, 1'b0, 16'h0000});
        @(negedge clk);
        check("wr_setup_psel", 32'(psel), 32'h1);
        check("wr_setup_pen", 32'(penable), 32'd0);
        check("wr_setup_bus", 32'({paddr, pwdata}), 32'({20'h00010, 16'h1234}));
        check("wr_setup_ctl", 32'({pwrite, pstrb}), 32'h7);
        @(negedge clk);
        check("wr_access", 32'({psel, penable}), 32'h3);
        @(negedge clk);
        check("wr_done0", 32'({done0, done1, psel, penable}), 32'h10);
        req0 = 1'b0;
        @(negedge clk);
        check("wr_cleared", 32'({done0, err, rdata}), 32'd0);

        // read from slave 1 with three wait states; payload change after grant is ignored
        req1 = 1'b1; addr1 = 20'h80004; write1 = 1'b0; wdata1 = 16'hFFFF; strb1 = 2'b11;
        slv_wait = 3; slv_rdata = 16'hABCD;
        exp_q.push_back({1'b1, 1'b0, 16'hABCD});
        @(negedge clk);
        check("rd_setup", 32'({psel, pwrite, pstrb, pwdata}), 32'({2'b10, 1'b0, 2'b00, 16'h0}));
        addr1 = 20'h00000;
        wait_done(20, cyc);
        check("rd_latency", 32'(cyc + 1), 32'd6);
        req1 = 1'b0;
        @(negedge clk);
        check("rd_cleared", 32'({done1, rdata}), 32'd0);

        // contention: both held, grants must alternate 0,1,0,1
        req0 = 1'b1; addr0 = 20'h00020; wdata0 = 16'h5555; write0 = 1'b1;
        req1 = 1'b1; addr1 = 20'h80020; write1 = 1'b0;
        slv_wait = $urandom_range(0, 2); slv_rdata = 16'h5A5A;
        exp_q.push_back({1'b0, 1'b0, 16'h0000});
        exp_q.push_back({1'b1, 1'b0, 16'h5A5A});
        exp_q.push_back({1'b0, 1'b0, 16'h0000});
        exp_q.push_back({1'b1, 1'b0, 16'h5A5A});
        for (int i = 0; i < 4; i++) begin
            wait_done(20, cyc);
            if (i == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        @(negedge clk);
        check("cont_drained", 32'(exp_q.size()), 32'd0);

        // slave error, then a clean transfer
        slv_wait = 0; slv_err = 1'b1;
        req0 = 1'b1;
        exp_q.push_back({1'b0, 1'b1, 16'h0000});
        wait_done(20, cyc);
        req0 = 1'b0; slv_err = 1'b0;
        @(negedge clk);
        check("err_cleared", 32'(err), 32'd0);
        req1 = 1'b1; slv_rdata = 16'h0F0F;
        exp_q.push_back({1'b1, 1'b0, 16'h0F0F});
        wait_done(20, cyc);
        req1 = 1'b0;
        @(negedge clk);

        // reset while in ACCESS, then tie goes to requester 0
        req0 = 1'b1; slv_wait = 1000;
        @(negedge clk);
        @(negedge clk);
        check("rst_pre_access", 32'(penable), 32'd1);
        #2 reset_n = 1'b0;
        #1 check("rst_async", 32'({psel, penable, done0, done1}), 32'd0);
        check("rst_async_addr", 32'(paddr), 32'd0);
        req0 = 1'b0;
        @(negedge clk);
        slv_wait = 0;
        req0 = 1'b1; req1 = 1'b1;
        reset_n = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 16'h0000});
        wait_done(20, cyc);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);

        // slave never responds
        slv_wait = 100000;
        req0 = 1'b1;
`ifdef APB_TIMEOUT_EN
        exp_q.push_back({1'b0, 1'b1, 16'hDEAD});
        wait_done(40, cyc);
        check("to_latency", 32'(cyc), 32'd10);
        req0 = 1'b0;
        @(negedge clk);
        check("to_cleared", 32'({err, rdata, penable}), 32'd0);
`else
        repeat (100) @(negedge clk);
        check("hang_waiting", 32'({psel, penable, done0}), 32'h6);
        reset_n = 1'b0;
        req0 = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
`endif
        @(negedge clk);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
